// File: rtl/requant_pack_if.sv
// Element-in / packed-word-out stream bundle for requant_pack, with the per-tensor
// quantisation config that travels alongside the element stream.
interface requant_pack_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_W-1:0]     in_data;
  logic [ACC_W-1:0]     in_bias;
  logic                 in_last;

  logic [ACC_W-1:0]     cfg_mult;
  logic [4:0]           cfg_shift;
  logic [7:0]           cfg_zp;
  logic [7:0]           cfg_act_min;
  logic [7:0]           cfg_act_max;

  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [LANES-1:0]     out_keep;
  logic                 out_last;

  // Producer of elements and consumer of words.
  modport master (
    output in_valid, in_data, in_bias, in_last,
    output cfg_mult, cfg_shift, cfg_zp, cfg_act_min, cfg_act_max,
    output out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  // The requantiser itself.
  modport slave (
    input  in_valid, in_data, in_bias, in_last,
    input  cfg_mult, cfg_shift, cfg_zp, cfg_act_min, cfg_act_max,
    input  out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/requant_pack.sv
// Bias add + TFLite-style requantisation of int32 accumulator sums to int8, packing
// LANES results per output word. Four datapath stages feed a pack/output register.
module requant_pack #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 32
) (
  input logic           clk,
  input logic           reset,
  requant_pack_if.slave bus
);

  localparam int unsigned CntW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ProdW = 2 * ACC_W;
  localparam int unsigned VW    = ACC_W + 2;

  localparam logic signed [ACC_W-1:0] AccMin   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] AccMax   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ProdW-1:0] NudgePos = ProdW'(1) << (ACC_W - 2);
  localparam logic signed [ProdW-1:0] NudgeNeg = ProdW'(1) - NudgePos;
  localparam logic signed [ProdW-1:0] TruncFix = (ProdW'(1) << (ACC_W - 1)) - ProdW'(1);

  // Whole pipeline freezes while a word sits unaccepted on the output.
  logic adv;
  assign adv          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = adv;

  // Stage registers
  logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [ACC_W-1:0] s1_x_q, s1_x_d;
  logic                    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic                    s2_sat_q, s2_sat_d;
  logic signed [ProdW-1:0] s2_p_q, s2_p_d;
  logic                    s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic signed [ACC_W-1:0] s3_h_q, s3_h_d;
  logic                    s4_valid_q, s4_valid_d, s4_last_q, s4_last_d;
  logic [7:0]              s4_byte_q, s4_byte_d;

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [8*LANES-1:0]      pack_q, pack_d;
  logic [LANES-1:0]        keep_q, keep_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [8*LANES-1:0]      out_data_q, out_data_d;
  logic [LANES-1:0]        out_keep_q, out_keep_d;

  // S2 math: full-width signed product and the single overflowing operand pair.
  logic signed [ACC_W-1:0] mult_s;
  logic signed [ProdW-1:0] x_ext, m_ext, prod;
  logic                    sat;

  always_comb begin
    mult_s = bus.cfg_mult;
    x_ext  = ProdW'(s1_x_q);
    m_ext  = ProdW'(mult_s);
    prod   = x_ext * m_ext;
    sat    = (s1_x_q == AccMin) && (mult_s == AccMin);
  end

  // S3 math: round-to-nearest high half, then divide truncating toward zero.
  logic signed [ProdW-1:0] rnd_sum, rnd_adj;
  logic signed [ACC_W-1:0] h_calc;

  always_comb begin
    rnd_sum = s2_p_q + (s2_p_q[ProdW-1] ? NudgeNeg : NudgePos);
    rnd_adj = rnd_sum + (rnd_sum[ProdW-1] ? TruncFix : '0);
    h_calc  = s2_sat_q ? AccMax : ACC_W'(rnd_adj >>> (ACC_W - 1));
  end

  // S4 math: rounding shift (half away from zero), zero point, clamp.
  logic [ACC_W-1:0]        mask, rem, thr;
  logic                    rnd_up;
  logic signed [ACC_W-1:0] h_sh;
  logic signed [7:0]       zp_s, min_s, max_s;
  logic signed [VW-1:0]    v, lo, hi;
  logic [7:0]              q;

  always_comb begin
    mask   = (ACC_W'(1) << bus.cfg_shift) - ACC_W'(1);
    rem    = s3_h_q & mask;
    thr    = (mask >> 1) + ACC_W'(s3_h_q[ACC_W-1]);
    rnd_up = rem > thr;
    h_sh   = s3_h_q >>> bus.cfg_shift;
    zp_s   = bus.cfg_zp;
    min_s  = bus.cfg_act_min;
    max_s  = bus.cfg_act_max;
    v      = VW'(h_sh) + VW'(rnd_up) + VW'(zp_s);
    lo     = VW'(min_s);
    hi     = VW'(max_s);
    if (v < lo) begin
      q = bus.cfg_act_min;
    end else if (v > hi) begin
      q = bus.cfg_act_max;
    end else begin
      q = v[7:0];
    end
  end

  // Next state for every stage, gated as a whole by adv.
  logic [8*LANES-1:0] word;
  logic [LANES-1:0]   word_keep;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_x_d      = s1_x_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s2_sat_d    = s2_sat_q;
    s2_p_d      = s2_p_q;
    s3_valid_d  = s3_valid_q;
    s3_last_d   = s3_last_q;
    s3_h_d      = s3_h_q;
    s4_valid_d  = s4_valid_q;
    s4_last_d   = s4_last_q;
    s4_byte_d   = s4_byte_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    keep_d      = keep_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    word        = pack_q;
    word_keep   = keep_q;

    if (adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_x_d    = bus.in_data + bus.in_bias;
        s1_last_d = bus.in_last;
      end

      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_sat_d   = sat;
      s2_p_d     = prod;

      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      s3_h_d     = h_calc;

      s4_valid_d = s3_valid_q;
      s4_last_d  = s3_last_q;
      s4_byte_d  = q;

      // A handshake (or an idle output) always clears out_valid unless a word completes.
      out_valid_d = 1'b0;
      if (s4_valid_q) begin
        word[8*cnt_q +: 8] = s4_byte_q;
        word_keep[cnt_q]   = 1'b1;
        if ((cnt_q == CntW'(LANES - 1)) || s4_last_q) begin
          out_valid_d = 1'b1;
          out_data_d  = word;
          out_keep_d  = word_keep;
          out_last_d  = s4_last_q;
          pack_d      = '0;
          keep_d      = '0;
          cnt_d       = '0;
        end else begin
          pack_d = word;
          keep_d = word_keep;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_x_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sat_q    <= 1'b0;
      s2_p_q      <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_h_q      <= '0;
      s4_valid_q  <= 1'b0;
      s4_last_q   <= 1'b0;
      s4_byte_q   <= '0;
      cnt_q       <= '0;
      pack_q      <= '0;
      keep_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_x_q      <= s1_x_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_sat_q    <= s2_sat_d;
      s2_p_q      <= s2_p_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      s3_h_q      <= s3_h_d;
      s4_valid_q  <= s4_valid_d;
      s4_last_q   <= s4_last_d;
      s4_byte_q   <= s4_byte_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      keep_q      <= keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_requant_pack.sv
// Bench for requant_pack: table of single-element vectors, a reference model for random
// batches under back-pressure, and hand sequences for pack, stall and mid-stream reset.
module tb_requant_pack;

  logic clk = 1'b0;
  logic reset;

  requant_pack_if #(.LANES(4), .ACC_W(32)) bus ();

  requant_pack #(.LANES(4), .ACC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         data;
    int         bias;
    int         mult;
    int         shift;
    int         zp;
    int         amin;
    int         amax;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_data  = '0;
  logic [3:0]  m_keep  = '0;
  int          m_cnt   = 0;
  bit          bp_on   = 1'b0;
  vec_t        vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Expected-word builder, fed in acceptance order.
  function automatic void model_push(input logic [7:0] b, input logic last);
    word_t w;
    m_data[8*m_cnt +: 8] = b;
    m_keep[m_cnt]        = 1'b1;
    if (m_cnt == 3 || last) begin
      w.data = m_data;
      w.keep = m_keep;
      w.last = last;
      exp_q.push_back(w);
      m_data = '0;
      m_keep = '0;
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
  endfunction

  // Reference: exact arithmetic, rounding half away from zero.
  function automatic logic [7:0] ref_q(input int d, input int b, input int m, input int sh,
                                       input int zp, input int mn, input int mx);
    int     x;
    longint p, h, dv, half, r, v;
    x = d + b;
    if (x == 32'sh80000000 && m == 32'sh80000000) begin
      h = 64'sd2147483647;
    end else begin
      p = longint'(x) * longint'(m);
      if (p >= 0) h = (p + 64'sd1073741824) / 64'sd2147483648;
      else        h = (p + 64'sd1 - 64'sd1073741824) / 64'sd2147483648;
    end
    dv   = 64'sd1 <<< sh;
    half = dv / 2;
    if (h >= 0) r = (h + half) / dv;
    else        r = -((-h + half) / dv);
    v = r + zp;
    if (v < mn) v = mn;
    if (v > mx) v = mx;
    return v[7:0];
  endfunction

  task automatic set_cfg(input int mult, input int sh, input int zp, input int mn, input int mx);
    bus.cfg_mult    = mult;
    bus.cfg_shift   = 5'(sh);
    bus.cfg_zp      = 8'(zp);
    bus.cfg_act_min = 8'(mn);
    bus.cfg_act_max = 8'(mx);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input int data, input int bias, input logic last, input logic [7:0] exp,
                      input bit track);
    int waited = 0;
    bus.in_data  = data;
    bus.in_bias  = bias;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        check("in_ready wait", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (track) model_push(exp, last);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each accepted word against the oldest expectation.
  always @(negedge clk) begin
    word_t w;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra word: got %08h keep %h, required none", bus.out_data, bus.out_keep);
      end else begin
        w = exp_q.pop_front();
        check("word data", 64'(bus.out_data), 64'(w.data));
        check("word keep", 64'(bus.out_keep), 64'(w.keep));
        check("word last", 64'(bus.out_last), 64'(w.last));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    int          wcnt;

    //          data          bias  mult          sh  zp    min   max  exp
    vecs[0]  = '{-300,         0,   32'sh40000000, 2, -10, -128, 127, 8'hD0};
    vecs[1]  = '{900,          100, 32'sh40000000, 0, 0,   -128, 127, 8'h7F};
    vecs[2]  = '{-1000,        0,   32'sh40000000, 0, 0,   -128, 127, 8'h80};
    vecs[3]  = '{100,          0,   32'sh40000000, 0, 0,   0,    6,   8'h06};
    vecs[4]  = '{32'sh80000000, 0,  32'sh80000000, 31, 0,  -128, 127, 8'h01};
    vecs[5]  = '{12,           0,   32'sh40000000, 2, 0,   -128, 127, 8'h02};
    vecs[6]  = '{-12,          0,   32'sh40000000, 2, 0,   -128, 127, 8'hFE};
    vecs[7]  = '{20,           0,   32'sh40000000, 1, 5,   -128, 127, 8'h0A};
    vecs[8]  = '{10,           0,   32'shC0000000, 0, 0,   -128, 127, 8'hFB};
    vecs[9]  = '{32'sh7FFFFFFF, 1,  32'sh40000000, 0, 0,   -128, 127, 8'h80};
    vecs[10] = '{-10,          0,   32'sh40000000, 1, 0,   -128, 127, 8'hFD};
    vecs[11] = '{10,           0,   32'sh40000000, 1, 0,   -128, 127, 8'h03};
    vecs[12] = '{1000,         0,   32'sh40000000, 0, 127, -128, 127, 8'h7F};
    vecs[13] = '{40,           0,   32'sh40000000, 0, -128, -128, 127, 8'h94};
    vecs[14] = '{-7,           0,   32'sh40000000, 31, 0,  -128, 127, 8'h00};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bias   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    set_cfg(32'sh40000000, 0, 0, -128, 127);
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_data", 64'(bus.out_data), 64'd0);
    check("reset out_keep", 64'(bus.out_keep), 64'd0);
    check("reset out_last", 64'(bus.out_last), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Four-lane pack, last on the fourth element.
    send(2, 0, 1'b0, 8'h01, 1'b1);
    send(4, 0, 1'b0, 8'h02, 1'b1);
    send(6, 0, 1'b0, 8'h03, 1'b1);
    send(8, 0, 1'b1, 8'h04, 1'b1);
    wait_drain();

    for (int i = 0; i < 15; i++) begin
      set_cfg(vecs[i].mult, vecs[i].shift, vecs[i].zp, vecs[i].amin, vecs[i].amax);
      send(vecs[i].data, vecs[i].bias, 1'b1, vecs[i].exp, 1'b1);
      wait_drain();
    end

    // Random batches against the reference model with random back-pressure.
    bp_on = 1'b1;
    fork
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join_none
    for (int bt = 0; bt < 8; bt++) begin
      int mult, sh, zp, a, b, mn, mx;
      mult = int'($urandom);
      sh   = $urandom_range(16, 31);
      zp   = int'($signed(8'($urandom)));
      a    = int'($signed(8'($urandom)));
      b    = int'($signed(8'($urandom)));
      mn   = (a < b) ? a : b;
      mx   = (a < b) ? b : a;
      set_cfg(mult, sh, zp, mn, mx);
      for (int e = 0; e < 4; e++) begin
        int d, bi;
        d  = int'($urandom);
        bi = int'($urandom_range(0, 2000)) - 1000;
        send(d, bi, (e == 3), ref_q(d, bi, mult, sh, zp, mn, mx), 1'b1);
      end
      wait_drain();
    end
    bp_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Partial flush with a three-cycle stall on the first word.
    set_cfg(32'sh40000000, 0, 0, -128, 127);
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send(2 * k, 0, (k == 6), 8'(k), 1'b1);
        end
      end
      begin
        wcnt = 0;
        while (!bus.out_valid && wcnt < 100) begin
          @(posedge clk);
          #1;
          wcnt++;
        end
        check("stall word seen", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        snap = bus.out_data;
        repeat (3) begin
          @(negedge clk);
          check("stall in_ready", 64'(bus.in_ready), 64'd0);
          check("stall out_valid", 64'(bus.out_valid), 64'd1);
          check("stall out_data", 64'(bus.out_data), 64'(snap));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset after two untracked elements; nothing may come out of them.
    send(2, 0, 1'b0, 8'h00, 1'b0);
    send(4, 0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
    check("mid reset in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post reset out_valid", 64'(bus.out_valid), 64'd0);
    send(2, 0, 1'b0, 8'h01, 1'b1);
    send(4, 0, 1'b0, 8'h02, 1'b1);
    send(6, 0, 1'b0, 8'h03, 1'b1);
    send(8, 0, 1'b0, 8'h04, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
